// File: rtl/counter_ctrl.sv
// counter_ctrl: burst/prescale controller for the downstream 4-bit counter.
//
// Accepting a start latches a prescale divisor and a burst length. The block
// then issues one-cycle enable pulses every div_q+1 clocks. It stops when the
// burst completes or when an abort arrives, and then raises done for one cycle.
//
// Ports:
//   clk       - system clock; all state updates on the rising edge
//   rst       - synchronous active-low reset
//   start     - begin a burst (honoured only in IDLE)
//   abort     - terminate a burst (honoured only in RUN)
//   pre_div   - enable period minus 1, latched on an accepted start
//   burst_len - number of enable pulses, 0 = continuous; latched on start
//   en        - enable pulse to the downstream counter
//   busy      - high while in RUN
//   done      - one-cycle completion pulse
//   pulses    - en pulses issued in the current or most recent burst
module counter_ctrl #(
    parameter int PRE_W = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PRE_W-1:0] pre_div,
    input  logic [LEN_W-1:0] burst_len,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] pulses
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [PRE_W-1:0]   div_q;
    logic [LEN_W-1:0]   len_q;
    logic [PRE_W-1:0]   pc;
    logic [LEN_W-1:0]   pulses_q;
    logic [LEN_W-1:0]   pulses_inc;
    logic               last_pulse;

    assign pulses_inc = pulses_q + 1'b1;
    // The final pulse of a finite burst; len_q == 0 means continuous mode.
    assign last_pulse = (len_q != '0) && (pulses_inc == len_q);
    assign pulses     = pulses_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Next state and outputs. en is combinational from registered state,
    // so it is stable for the whole cycle. An abort in the same cycle masks it.
    always_comb begin
        state_d = state;
        en      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                en   = (pc == div_q) && !abort;
                if (abort)                  state_d = DONE;
                else if (en && last_pulse)  state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latched parameters, prescale count, pulse tally
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q    <= '0;
            len_q    <= '0;
            pc       <= '0;
            pulses_q <= '0;
        end else begin
            if (state == IDLE && start) begin
                div_q    <= pre_div;
                len_q    <= burst_len;
                pc       <= '0;
                pulses_q <= '0;
            end else if (state == RUN && !abort) begin
                if (en) begin
                    pc       <= '0;
                    pulses_q <= pulses_inc;
                end else begin
                    pc       <= pc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl. Traces record en/busy/done per RUN cycle
// (bit c = cycle c after the start-accepting edge). A simple 4-bit counter
// model sits on en to stand in for the downstream counter.
module tb_counter_ctrl;

    localparam int PRE_W = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [PRE_W-1:0] pre_div;
    logic [LEN_W-1:0] burst_len;
    logic             en;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] pulses;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] en_tr, busy_tr, done_tr;
    logic [3:0]  cnt;

    counter_ctrl #(.PRE_W(PRE_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pre_div   (pre_div),
        .burst_len (burst_len),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .pulses    (pulses)
    );

    always #5 clk = ~clk;

    // Downstream counter model, shares reset with the controller
    always @(posedge clk) begin
        if (!rst)    cnt <= 4'd0;
        else if (en) cnt <= cnt + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a start, then trace ncyc RUN-relative cycles. abort is raised in
    // cycle ab (-1 = never). With hold set, start stays high and the inputs
    // change during the burst; start drops in cycle 5.
    task automatic burst(input int div, input int len, input int ab,
                         input int ncyc, input bit hold);
        start     = 1'b1;
        pre_div   = PRE_W'(div);
        burst_len = LEN_W'(len);
        step();
        if (hold) begin
            pre_div   = 4'd3;
            burst_len = 8'd9;
        end else begin
            start = 1'b0;
        end
        en_tr = '0; busy_tr = '0; done_tr = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (hold && c == 5) start = 1'b0;
            abort = (c == ab);
            #1;
            if (c < 32) begin
                en_tr[c]   = en;
                busy_tr[c] = busy;
                done_tr[c] = done;
            end
            step();
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; abort = 1'b0; pre_div = 4'd0; burst_len = 8'd5;
        #1;

        // Reset held with start asserted
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_en",     32'(en),     32'd0);
            chk("rst_busy",   32'(busy),   32'd0);
            chk("rst_done",   32'(done),   32'd0);
            chk("rst_pulses", 32'(pulses), 32'd0);
        end
        start = 1'b0;
        rst   = 1'b1;
        step();
        chk("rst_norun", 32'(busy), 32'd0);

        // pre_div=0, burst_len=4
        burst(0, 4, -1, 8, 1'b0);
        chk("d0l4_en",   en_tr,   32'h0F);
        chk("d0l4_busy", busy_tr, 32'h0F);
        chk("d0l4_done", done_tr, 32'h10);
        chk("d0l4_puls", 32'(pulses), 32'd4);
        chk("d0l4_cnt",  32'(cnt),    32'd4);

        // pre_div=2, burst_len=3
        burst(2, 3, -1, 12, 1'b0);
        chk("d2l3_en",   en_tr,   32'h124);
        chk("d2l3_busy", busy_tr, 32'h1FF);
        chk("d2l3_done", done_tr, 32'h200);
        chk("d2l3_puls", 32'(pulses), 32'd3);

        // Continuous mode aborted in cycle 7
        burst(1, 0, 7, 10, 1'b0);
        chk("cont_en",   en_tr,   32'h2A);
        chk("cont_busy", busy_tr, 32'hFF);
        chk("cont_done", done_tr, 32'h100);
        chk("cont_puls", 32'(pulses), 32'd3);

        // Inputs changed and start held during a burst
        burst(1, 2, -1, 8, 1'b1);
        chk("hold_en",   en_tr,   32'h0A);
        chk("hold_busy", busy_tr, 32'h0F);
        chk("hold_done", done_tr, 32'h10);
        chk("hold_puls", 32'(pulses), 32'd2);

        // Mid-burst reset in cycle 3
        start = 1'b1; pre_div = 4'd0; burst_len = 8'd10;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mrst_en",     32'(en),     32'd0);
        chk("mrst_busy",   32'(busy),   32'd0);
        chk("mrst_done",   32'(done),   32'd0);
        chk("mrst_pulses", 32'(pulses), 32'd0);
        step();
        chk("mrst_nodone", 32'(done), 32'd0);
        burst(0, 2, -1, 5, 1'b0);
        chk("post_en",   en_tr,   32'h03);
        chk("post_done", done_tr, 32'h04);
        chk("post_puls", 32'(pulses), 32'd2);

        // Continuous wrap: 257 pulses with pre_div=0, aborted in cycle 257
        burst(0, 0, 257, 260, 1'b0);
        chk("wrap_puls", 32'(pulses), 32'd1);
        chk("wrap_idle", 32'(busy),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
